// File: rtl/partial_sum_generator.sv
// partial_sum_generator: per-neuron MAC front end producing saturated products for an external accumulator.
module partial_sum_generator #(
    parameter int FRAC_W = 8,
    parameter int CNT_W  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_inputs,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      activation,
    input  logic [15:0]      weight,
    output logic [15:0]      partial_sum,
    output logic             add_done,
    output logic             neuron_done,
    input  logic [15:0]      new_sum,
    output logic [15:0]      result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, MAC, SETTLE, DONE, OUT} state_t;
    state_t state, next_state;
    logic [CNT_W-1:0] target, count, count_inc;
    logic [1:0] settle_cnt;
    logic fire, last, accept, settle_end;
    logic signed [31:0] act_ext, wgt_ext, product, shifted;
    logic [15:0] sat;
    assign fire       = in_valid && in_ready;
    assign count_inc  = count + CNT_W'(1);
    assign last       = fire && (count_inc == target);
    assign accept     = (state == IDLE) && start && (num_inputs != '0);
    assign settle_end = (state == SETTLE) && (settle_cnt == 2'd2);
    assign act_ext    = {{16{activation[15]}}, activation};
    assign wgt_ext    = {{16{weight[15]}}, weight};
    assign product    = act_ext * wgt_ext;
    assign shifted    = product >>> FRAC_W;
    assign sat        = shifted > 32'sd32767  ? 16'h7FFF :
                        shifted < -32'sd32768 ? 16'h8000 : shifted[15:0];
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? MAC : IDLE;
            MAC:     next_state = last ? SETTLE : MAC;
            SETTLE:  next_state = settle_end ? DONE : SETTLE;
            DONE:    next_state = OUT;
            OUT:     next_state = out_ready ? IDLE : OUT;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        in_ready    = state == MAC;
        busy        = state != IDLE;
        neuron_done = state == DONE;
        out_valid   = state == OUT;
    end
    // settle_cnt spans the final add, accumulator register and its saturation fix-up
    always_ff @(posedge clk) begin
        if (!reset) begin
            target      <= '0;
            count       <= '0;
            settle_cnt  <= '0;
            partial_sum <= '0;
            add_done    <= 1'b0;
            result      <= '0;
        end else begin
            add_done   <= fire;
            settle_cnt <= state == SETTLE ? settle_cnt + 2'd1 : 2'd0;
            if (fire) partial_sum <= sat;
            if (accept) begin
                target <= num_inputs;
                count  <= '0;
            end else if (fire) begin
                count <= count_inc;
            end
            if (settle_end) result <= new_sum;
        end
    end
endmodule

// File: doc/partial_sum_generator.md
PARTIAL_SUM_GENERATOR -- requirements
Module: partial_sum_generator

Interface
REQ-001 Parameter FRAC_W, default 8: fractional bits of the signed Q(16-FRAC_W).FRAC_W operands and result.
REQ-002 Parameter CNT_W, default 10: width of the input-count field.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low; clock clk.
REQ-005 start  input  1  one-cycle request to begin one neuron; honoured only in IDLE.
REQ-006 num_inputs  input  CNT_W  number of activation/weight pairs for the neuron; sampled on accepted start.
REQ-007 in_valid  input  1  activation/weight pair present.
REQ-008 in_ready  output  1  block accepts a pair this cycle.
REQ-009 activation  input  16  signed fixed-point activation.
REQ-010 weight  input  16  signed fixed-point weight.
REQ-011 partial_sum  output  16  saturated product, sent to the accumulation register.
REQ-012 add_done  output  1  one-cycle strobe: partial_sum is valid this cycle.
REQ-013 neuron_done  output  1  one-cycle strobe: accumulation register clears.
REQ-014 new_sum  input  16  running sum returned from the accumulation register.
REQ-015 result  output  16  captured final neuron sum.
REQ-016 out_valid  output  1  result valid; held until out_ready.
REQ-017 out_ready  input  1  downstream accepts result.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, MAC, SETTLE, DONE, OUT.
REQ-020 IDLE: start=1 and num_inputs!=0 -> MAC, latch count target, clear counter; start with num_inputs==0 is ignored, stays IDLE.
REQ-021 MAC: in_ready=1; handshake is in_valid & in_ready; each handshake increments the counter.
REQ-022 Handshake at edge T -> partial_sum and add_done=1 registered for exactly the cycle after T (latency 1); add_done=0 when no handshake occurred in the prior cycle.
REQ-023 Back-to-back handshakes produce back-to-back add_done pulses; no bubbles are inserted.
REQ-024 Product: signed 16x16 -> 32-bit, arithmetic shift right by FRAC_W (truncation toward negative infinity).
REQ-025 Shifted product > 32767 -> partial_sum=0x7FFF; < -32768 -> partial_sum=0x8000; otherwise low 16 bits.
REQ-026 Handshake number num_inputs -> next state SETTLE; in_ready=0 from that cycle on.
REQ-027 SETTLE lasts exactly 3 cycles (final add_done cycle, accumulator register cycle, accumulator saturation-correction cycle); no handshakes.
REQ-028 SETTLE exit -> DONE: result <= new_sum; neuron_done=1 for this single cycle.
REQ-029 DONE -> OUT unconditionally; out_valid=1 in OUT.
REQ-030 OUT: out_ready=1 -> out_valid=0 next cycle, state IDLE; result holds its value until the next DONE.
REQ-031 start in any state other than IDLE is ignored; num_inputs changes after acceptance have no effect.
REQ-032 in_valid outside MAC is ignored; no add_done is generated.
REQ-033 Counter width CNT_W; num_inputs = 2^CNT_W-1 completes without wrap.

Reset
REQ-034 reset=0 at a clock edge, in any state: state=IDLE; counter=0; partial_sum=0, add_done=0, neuron_done=0, result=0, out_valid=0, in_ready=0, busy=0.
REQ-035 Reset mid-MAC discards in-flight pairs; no add_done and no neuron_done follow the reset.

Verification
REQ-036 start, num_inputs=1, pair 0x0200*0x0300 -> partial_sum=0x0600 with add_done one cycle after handshake; neuron_done 3 cycles later; result=new_sum.
REQ-037 Saturation: 0x7FFF*0x7FFF -> 0x7FFF; 0x8000*0x7FFF -> 0x8000; 0xFF00*0x0200 -> 0xFE00.
REQ-038 num_inputs=4, in_valid continuous -> four consecutive add_done pulses, then in_ready=0, neuron_done exactly once.
REQ-039 in_valid toggled randomly, num_inputs=3 -> exactly 3 add_done pulses; start pulsed mid-MAC has no effect.
REQ-040 out_ready held 0 for 5 cycles in OUT -> out_valid and result stable; out_ready=1 -> IDLE next cycle.
REQ-041 reset=0 during MAC after 2 of 4 pairs -> all outputs 0 next cycle; new start, num_inputs=1 runs normally.
